// File: rtl/awgn_normalizer.sv
// Leading-one normalizer: 3-stage valid/ready pipeline producing a bit-5 mantissa,
// a bit-30 mantissa and the 6-bit exponent code consumed by shiftere.
module awgn_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] x_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] e_out,
  output logic [30:0] m_full,
  output logic [5:0]  exp_f,
  output logic        zero
);

  logic        v1, v2, v3;
  logic [30:0] x1, x2;
  logic        z1, z2;
  logic [4:0]  p_enc, p2;
  logic        ld1, ld2, ld3;
  logic [30:0] e_nxt, m_nxt;
  logic [5:0]  exp_nxt;

  // A stage loads whenever it is empty or its contents move on this edge.
  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      x1 <= '0;
      z1 <= 1'b0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        x1 <= x_in;
        z1 <= (x_in == 31'd0);
      end
    end
  end

  always_comb begin
    p_enc = '0;
    for (int i = 0; i < 31; i++) begin
      if (x1[i]) p_enc = i[4:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      x2 <= '0;
      z2 <= 1'b0;
      p2 <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        x2 <= x1;
        z2 <= z1;
        p2 <= p_enc;
      end
    end
  end

  // Exponent code is 5 - p; left shift when the leading one is at or below bit 5.
  always_comb begin
    e_nxt   = '0;
    m_nxt   = '0;
    exp_nxt = '0;
    if (!z2) begin
      if (p2 <= 5'd5) e_nxt = x2 << (5'd5 - p2);
      else            e_nxt = x2 >> (p2 - 5'd5);
      m_nxt   = x2 << (5'd30 - p2);
      exp_nxt = 6'd5 - {1'b0, p2};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3     <= 1'b0;
      e_out  <= '0;
      m_full <= '0;
      exp_f  <= '0;
      zero   <= 1'b0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        e_out  <= e_nxt;
        m_full <= m_nxt;
        exp_f  <= exp_nxt;
        zero   <= z2;
      end
    end
  end

endmodule

// File: tb/tb_awgn_normalizer.sv
// Self-checking bench for awgn_normalizer: directed vectors, back-pressure,
// mid-stream reset and a randomized sweep scored against an arithmetic model.
module tb_awgn_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] e_out;
  logic [30:0] m_full;
  logic [5:0]  exp_f;
  logic        zero;

  int checks = 0;
  int failures = 0;
  int acceptCount = 0;
  logic [30:0] expQ[$];
  logic        holdValid = 1'b0;
  logic [69:0] holdVec;

  logic [30:0] bpVals[5];
  logic [5:0]  bpExp[5];

  awgn_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .e_out     (e_out),
    .m_full    (m_full),
    .exp_f     (exp_f),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Normalization computed from the leading-one position by plain arithmetic.
  function automatic void refModel(input logic [30:0] x, output logic [30:0] e,
                                   output logic [30:0] m, output logic [5:0] ex,
                                   output logic z, output int p);
    longint unsigned xv, ev, mv;
    xv = 64'(x);
    p = 30;
    if (x == 31'd0) begin
      e = '0; m = '0; ex = '0; z = 1'b1; p = 0;
      return;
    end
    while (xv < (64'd1 << p)) p--;
    if (p <= 5) ev = xv << (5 - p);
    else        ev = xv >> (p - 5);
    mv = xv << (30 - p);
    e  = ev[30:0];
    m  = mv[30:0];
    ex = 6'(5 - p);
    z  = 1'b0;
  endfunction

  function automatic logic [30:0] shiftere(input logic [30:0] e, input logic [5:0] ex);
    int s;
    s = int'($signed(ex));
    if (s >= 0) return e >> s;
    else        return e << (-s);
  endfunction

  function automatic logic [30:0] randOperand();
    if ($urandom_range(0, 15) == 0) return '0;
    return 31'($urandom >> $urandom_range(1, 31));
  endfunction

  // Scoreboard: handshakes seen at the negedge complete on the following rising edge.
  always @(negedge clk) begin
    logic [30:0] xr, re, rm, keep;
    logic [5:0]  rex;
    logic        rz;
    int          rp;
    if (!rst_n) begin
      expQ.delete();
      holdValid = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out", 1, 0);
        end else begin
          xr = expQ.pop_front();
          refModel(xr, re, rm, rex, rz, rp);
          checkOutput("e_out", e_out, re);
          checkOutput("m_full", m_full, rm);
          checkOutput("exp_f", exp_f, rex);
          checkOutput("zero", zero, rz);
          keep = (rp > 5) ? (31'h7FFFFFFF << (rp - 5)) : 31'h7FFFFFFF;
          checkOutput("roundtrip", shiftere(e_out, exp_f), xr & keep);
        end
      end
      if (holdValid) checkOutput("hold", {out_valid, zero, exp_f, e_out, m_full}, holdVec);
      holdValid = out_valid && !out_ready;
      holdVec   = {out_valid, zero, exp_f, e_out, m_full};
      if (in_valid && in_ready) begin
        expQ.push_back(x_in);
        acceptCount++;
      end
    end
  end

  // One operand into an empty pipe; latency counts the acceptance edge as the first.
  task automatic applyStimulus(input logic [30:0] x, input logic [5:0] ex,
                               input logic [30:0] e, input logic [30:0] m, input logic z);
    int edges;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    x_in      = x;
    out_ready = 1'b1;
    checkOutput("ready_before", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 12) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("latency", edges, 3);
    checkOutput("dir_exp_f", exp_f, ex);
    checkOutput("dir_e_out", e_out, e);
    checkOutput("dir_m_full", m_full, m);
    checkOutput("dir_zero", zero, z);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int idx, outIdx, cyc, startAcc, wait_cyc;
    bpVals = '{31'h10, 31'h200, 31'h4000, 31'h80000, 31'h1000000};
    bpExp  = '{6'd1, 6'b111100, 6'b110111, 6'b110010, 6'b101101};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_outputs", {zero, exp_f, e_out, m_full}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] directed vectors");
    applyStimulus(31'h00000001, 6'b000101, 31'h20, 31'h40000000, 1'b0);
    applyStimulus(31'h40000000, 6'b100111, 31'h20, 31'h40000000, 1'b0);
    applyStimulus(31'h00000035, 6'b000000, 31'h35, 31'h6A000000, 1'b0);
    applyStimulus(31'h00000000, 6'b000000, 31'h00, 31'h00000000, 1'b1);
    applyStimulus(31'h7FFFFFFF, 6'b100111, 31'h3F, 31'h7FFFFFFF, 1'b0);
    checkOutput("roundtrip_max", shiftere(31'h3F, 6'b100111), 31'h7E000000);

    $display("[TB] back-pressure");
    idx = 0; outIdx = 0;
    for (int c = 0; c < 60 && outIdx < 5; c++) begin
      @(posedge clk); #1;
      in_valid  = (idx < 5);
      x_in      = (idx < 5) ? bpVals[idx] : '0;
      out_ready = (c >= 5);
      @(negedge clk);
      if (c == 4) begin
        checkOutput("bp_accepts", idx, 3);
        checkOutput("bp_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        checkOutput("bp_exp_f", exp_f, bpExp[outIdx]);
        outIdx++;
      end
      if (in_valid && in_ready) idx++;
    end
    checkOutput("bp_results", outIdx, 5);
    @(posedge clk); #1;
    in_valid = 1'b0;

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      x_in = 31'h123 << (4 * k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_outputs", {zero, exp_f, e_out, m_full}, 0);
    rst_n = 1'b1;
    applyStimulus(31'h00000400, 6'b111011, 31'h20, 31'h40000000, 1'b0);

    $display("[TB] random sweep");
    startAcc = acceptCount;
    cyc = 0;
    while ((acceptCount - startAcc) < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 8);
      x_in      = randOperand();
      out_ready = ($urandom_range(0, 9) < 7);
      cyc++;
    end
    checkOutput("random_progress", (acceptCount - startAcc) >= 10000, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_cyc = 0;
    while (expQ.size() != 0 && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    checkOutput("drain_empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
